// File: rtl/traffic_phase_sequencer.sv
// Two-road traffic-light phase controller: Moore FSM with a shared phase timer
// and a latched side-road request that the main road yields to after minimum green.
module traffic_phase_sequencer #(
   parameter int unsigned MIN_GREEN  = 8,
   parameter int unsigned SIDE_GREEN = 6,
   parameter int unsigned YELLOW     = 3,
   parameter int unsigned ALL_RED    = 1,
   parameter int unsigned CNT_W      = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       car_det,
   input  logic       en,
   output logic [2:0] main_rgy,
   output logic [2:0] side_rgy,
   output logic [2:0] phase,
   output logic       req_pending
);

   localparam int unsigned PH_W   = 3;
   localparam int unsigned LAMP_W = 3;

   localparam logic [LAMP_W-1:0] LAMP_RED = 3'b100;
   localparam logic [LAMP_W-1:0] LAMP_YEL = 3'b010;
   localparam logic [LAMP_W-1:0] LAMP_GRN = 3'b001;

   localparam logic [CNT_W-1:0] LAST_MAIN_GREEN = CNT_W'(MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] LAST_SIDE_GREEN = CNT_W'(SIDE_GREEN - 1);
   localparam logic [CNT_W-1:0] LAST_YELLOW     = CNT_W'(YELLOW - 1);
   localparam logic [CNT_W-1:0] LAST_ALL_RED    = CNT_W'(ALL_RED - 1);

   typedef enum logic [PH_W-1:0] {
      ST_MAIN_GREEN  = 3'd0,
      ST_MAIN_YELLOW = 3'd1,
      ST_ALL_RED_A   = 3'd2,
      ST_SIDE_GREEN  = 3'd3,
      ST_SIDE_YELLOW = 3'd4,
      ST_ALL_RED_B   = 3'd5
   } state_t;

   state_t              state_q, state_d;
   state_t              succ;
   logic [CNT_W-1:0]    timer_q, timer_d;
   logic [CNT_W-1:0]    last;
   logic                req_q, req_d;
   logic [LAMP_W-1:0]   main_rgy_q, main_rgy_d;
   logic [LAMP_W-1:0]   side_rgy_q, side_rgy_d;

   // State, timer, request latch and registered lamp decode
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_MAIN_GREEN;
         timer_q    <= '0;
         req_q      <= 1'b0;
         main_rgy_q <= LAMP_GRN;
         side_rgy_q <= LAMP_RED;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         req_q      <= req_d;
         main_rgy_q <= main_rgy_d;
         side_rgy_q <= side_rgy_d;
      end
   end

   // Next-state, timer and request latch
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      req_d   = req_q;
      succ    = ST_MAIN_GREEN;
      last    = '0;

      case (state_q)
         ST_MAIN_GREEN:  begin last = LAST_MAIN_GREEN; succ = ST_MAIN_YELLOW; end
         ST_MAIN_YELLOW: begin last = LAST_YELLOW;     succ = ST_ALL_RED_A;   end
         ST_ALL_RED_A:   begin last = LAST_ALL_RED;    succ = ST_SIDE_GREEN;  end
         ST_SIDE_GREEN:  begin last = LAST_SIDE_GREEN; succ = ST_SIDE_YELLOW; end
         ST_SIDE_YELLOW: begin last = LAST_YELLOW;     succ = ST_ALL_RED_B;   end
         ST_ALL_RED_B:   begin last = LAST_ALL_RED;    succ = ST_MAIN_GREEN;  end
         default:        begin last = '0;              succ = ST_MAIN_GREEN;  end
      endcase

      // Car being served on the side road does not re-request
      if (car_det && (state_q != ST_SIDE_GREEN) && (state_q != ST_SIDE_YELLOW)) begin
         req_d = 1'b1;
      end

      case (state_q)
         ST_MAIN_GREEN: begin
            // Timer saturates at the minimum green until a request is pending
            if (en) begin
               if (timer_q == last) begin
                  if (req_q) begin
                     state_d = succ;
                     timer_d = '0;
                  end
               end else begin
                  timer_d = timer_q + CNT_W'(1);
               end
            end
         end
         ST_MAIN_YELLOW, ST_ALL_RED_A, ST_SIDE_GREEN, ST_SIDE_YELLOW, ST_ALL_RED_B: begin
            if (en) begin
               if (timer_q == last) begin
                  state_d = succ;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_MAIN_GREEN;
            timer_d = '0;
         end
      endcase

      if ((state_d == ST_SIDE_GREEN) && (state_q != ST_SIDE_GREEN)) begin
         req_d = 1'b0;
      end
   end

   // Lamp decode of the next state so the lamp flops track the state register
   always_comb begin
      main_rgy_d = LAMP_GRN;
      side_rgy_d = LAMP_RED;
      case (state_d)
         ST_MAIN_GREEN:  begin main_rgy_d = LAMP_GRN; side_rgy_d = LAMP_RED; end
         ST_MAIN_YELLOW: begin main_rgy_d = LAMP_YEL; side_rgy_d = LAMP_RED; end
         ST_ALL_RED_A:   begin main_rgy_d = LAMP_RED; side_rgy_d = LAMP_RED; end
         ST_SIDE_GREEN:  begin main_rgy_d = LAMP_RED; side_rgy_d = LAMP_GRN; end
         ST_SIDE_YELLOW: begin main_rgy_d = LAMP_RED; side_rgy_d = LAMP_YEL; end
         ST_ALL_RED_B:   begin main_rgy_d = LAMP_RED; side_rgy_d = LAMP_RED; end
         default:        begin main_rgy_d = LAMP_GRN; side_rgy_d = LAMP_RED; end
      endcase
   end

   assign phase       = state_q;
   assign req_pending = req_q;
   assign main_rgy    = main_rgy_q;
   assign side_rgy    = side_rgy_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Self-checking bench for traffic_phase_sequencer: directed scenarios plus
// randomized car/en traffic against a phase/elapsed-tick reference model.
module tb_traffic_phase_sequencer;

   localparam int MG = 8;
   localparam int SG = 6;
   localparam int YL = 3;
   localparam int AR = 1;
   localparam logic [9:0] IDLE_VEC = {3'd0, 3'b001, 3'b100, 1'b0};

   logic       clk;
   logic       rst;
   logic       car_det;
   logic       en;
   logic [2:0] main_rgy;
   logic [2:0] side_rgy;
   logic [2:0] phase;
   logic       req_pending;
   logic [9:0] obs;

   int vectors;
   int miscompares;

   // Reference model: current phase, ticks spent in it, pending request
   int m_phase;
   int m_ticks;
   bit m_req;

   traffic_phase_sequencer #(
      .MIN_GREEN(MG), .SIDE_GREEN(SG), .YELLOW(YL), .ALL_RED(AR), .CNT_W(4)
   ) dut (
      .clk(clk), .rst(rst), .car_det(car_det), .en(en),
      .main_rgy(main_rgy), .side_rgy(side_rgy), .phase(phase), .req_pending(req_pending)
   );

   assign obs = {phase, main_rgy, side_rgy, req_pending};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int dur_of(input int p);
      int d;
      d = (p == 0) ? MG : (p == 3) ? SG : (p == 1 || p == 4) ? YL : AR;
      return d;
   endfunction

   function automatic logic [2:0] main_exp(input int p);
      return (p == 0) ? 3'b001 : (p == 1) ? 3'b010 : 3'b100;
   endfunction

   function automatic logic [2:0] side_exp(input int p);
      return (p == 3) ? 3'b001 : (p == 4) ? 3'b010 : 3'b100;
   endfunction

   function automatic logic [9:0] exp_vec();
      return {3'(m_phase), main_exp(m_phase), side_exp(m_phase), 1'(m_req)};
   endfunction

   task automatic model_reset();
      m_phase = 0;
      m_ticks = 0;
      m_req   = 1'b0;
   endtask

   // One clock edge of the phase rules, using pre-edge values
   task automatic model_step(input bit car, input bit e);
      bit nreq;
      int np;
      nreq = m_req;
      np   = m_phase;
      if (car && m_phase != 3 && m_phase != 4) nreq = 1'b1;
      if (e) begin
         if (m_ticks + 1 >= dur_of(m_phase)) begin
            if (m_phase != 0 || m_req) begin
               np      = (m_phase + 1) % 6;
               m_ticks = 0;
            end
         end else begin
            m_ticks = m_ticks + 1;
         end
      end
      if (np == 3 && m_phase != 3) nreq = 1'b0;
      m_phase = np;
      m_req   = nreq;
   endtask

   task automatic step(input bit car, input bit e);
      car_det = car;
      en      = e;
      @(posedge clk);
      model_step(car, e);
      #1;
   endtask

   task automatic do_reset();
      rst     = 1'b0;
      car_det = 1'b0;
      en      = 1'b0;
      model_reset();
      #2;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst     = 1'b0;
      car_det = 1'b1;
      en      = 1'b1;
      model_reset();
      #2;
      @(posedge clk);
      #1;
      vectors++;
      if (obs !== IDLE_VEC) begin
         miscompares++;
         $display("FAIL reset_hold: got %b expected %b", obs, IDLE_VEC);
      end
      car_det = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_idle();
      do_reset();
      for (int c = 0; c < 50; c++) begin
         step(1'b0, 1'b1);
         vectors++;
         if (obs !== IDLE_VEC || obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL idle c=%0d: got %b expected %b", c, obs, IDLE_VEC);
         end
      end
   endtask

   task automatic test_service();
      logic [3:0] sched;
      do_reset();
      for (int c = 0; c <= 30; c++) begin
         sched[3:1] = (c < 8) ? 3'd0 : (c < 11) ? 3'd1 : (c == 11) ? 3'd2 :
                      (c < 18) ? 3'd3 : (c < 21) ? 3'd4 : (c == 21) ? 3'd5 : 3'd0;
         sched[0]   = (c >= 3 && c <= 11);
         vectors++;
         if ({phase, req_pending} !== sched) begin
            miscompares++;
            $display("FAIL service_sched c=%0d: got %b expected %b", c, {phase, req_pending}, sched);
         end
         step(c == 2, 1'b1);
         vectors++;
         if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL service_model c=%0d: got %b expected %b", c, obs, exp_vec());
         end
      end
   endtask

   task automatic test_late_request();
      do_reset();
      for (int c = 0; c <= 60; c++) begin
         if (c == 21 || c == 22) begin
            vectors++;
            if ({phase, req_pending} !== ((c == 21) ? 4'b0001 : 4'b0011)) begin
               miscompares++;
               $display("FAIL late_req c=%0d: got %b expected %b", c, {phase, req_pending},
                        (c == 21) ? 4'b0001 : 4'b0011);
            end
         end
         step((c == 20) || (c >= 26 && c <= 31 && (c % 2) == 0), 1'b1);
         vectors++;
         if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL late_model c=%0d: got %b expected %b", c, obs, exp_vec());
         end
      end
      vectors++;
      if ({phase, req_pending} !== 4'b0000) begin
         miscompares++;
         $display("FAIL late_settle: got %b expected %b", {phase, req_pending}, 4'b0000);
      end
   endtask

   task automatic test_en_stall();
      int sg_cycles;
      sg_cycles = 0;
      do_reset();
      for (int c = 0; c <= 40; c++) begin
         if (phase == 3'd3) sg_cycles++;
         step(c == 2, !(c >= 13 && c <= 16));
         vectors++;
         if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL stall_model c=%0d: got %b expected %b", c, obs, exp_vec());
         end
      end
      vectors++;
      if (sg_cycles != 10) begin
         miscompares++;
         $display("FAIL stall_side_green_len: got %0d expected %0d", sg_cycles, 10);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int c = 0; c < 19; c++) step(c == 2, 1'b1);
      vectors++;
      if (phase !== 3'd4) begin
         miscompares++;
         $display("FAIL arst_pre: got %0d expected %0d", phase, 4);
      end
      rst = 1'b0;
      model_reset();
      #2;
      vectors++;
      if (obs !== IDLE_VEC) begin
         miscompares++;
         $display("FAIL arst_between_edges: got %b expected %b", obs, IDLE_VEC);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 30; c++) begin
         step(c == 5, 1'b1);
         vectors++;
         if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL arst_resume c=%0d: got %b expected %b", c, obs, exp_vec());
         end
      end
   endtask

   task automatic test_clear_priority();
      logic [3:0] want;
      do_reset();
      for (int c = 0; c <= 32; c++) begin
         if (c == 12 || c == 22 || c == 29 || c == 30) begin
            want = (c == 12) ? 4'b0110 : (c == 30) ? 4'b0011 : 4'b0001;
            vectors++;
            if ({phase, req_pending} !== want) begin
               miscompares++;
               $display("FAIL clear_prio c=%0d: got %b expected %b", c, {phase, req_pending}, want);
            end
         end
         step((c == 2) || (c == 10) || (c == 11) || (c == 21), 1'b1);
         vectors++;
         if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL clear_model c=%0d: got %b expected %b", c, obs, exp_vec());
         end
      end
   endtask

   task automatic test_random();
      bit car;
      bit e;
      do_reset();
      for (int c = 0; c < 800; c++) begin
         car = ($urandom_range(0, 7) == 0);
         e   = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 199) == 0) begin
            rst = 1'b0;
            model_reset();
            #2;
            @(negedge clk);
            rst = 1'b1;
         end else begin
            step(car, e);
         end
         vectors++;
         if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL random c=%0d: got %b expected %b", c, obs, exp_vec());
         end
         vectors++;
         if (!($onehot(main_rgy) && $onehot(side_rgy) && (main_rgy[2] || side_rgy[2]))) begin
            miscompares++;
            $display("FAIL lamp_safety c=%0d: got main=%b side=%b", c, main_rgy, side_rgy);
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b0;
      car_det     = 1'b0;
      en          = 1'b0;
      model_reset();
      test_reset();
      test_idle();
      test_service();
      test_late_request();
      test_en_stall();
      test_async_reset();
      test_clear_priority();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
